// File: rtl/ifft_stream_pkg.sv
// ifft_stream_pkg: shared state type and derived-size helpers for the IFFT stream writer
package ifft_stream_pkg;

    typedef enum logic [1:0] {IDLE, CAPT, STRM} state_t;

    localparam int MAXTILE = 256;

    function automatic int cmplxlen(input int datalen);
        return 2 * datalen;
    endfunction

    function automatic int wpb(input int axiwidth, input int datalen);
        return axiwidth / cmplxlen(datalen);
    endfunction

    function automatic int wpt(input int nburst, input int fftchnl);
        return nburst * fftchnl * 2;
    endfunction

    function automatic int bpt(input int axiwidth, input int datalen, input int nburst, input int fftchnl);
        return wpt(nburst, fftchnl) / wpb(axiwidth, datalen);
    endfunction

    function automatic int clog2min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    // Lowest set mask bit at or above from; returns n when no such tile remains.
    function automatic int next_tile(input logic [MAXTILE-1:0] mask, input int from, input int n);
        int r;
        r = n;
        for (int i = n - 1; i >= 0; i--)
            if (i >= from && mask[8'(i)]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/tile_frame_buffer.sv
// tile_frame_buffer: one tile's frame store, written a burst row at a time, read a beat at a time
module tile_frame_buffer
    import ifft_stream_pkg::*;
#(
    parameter int FFTCHNL  = 8,
    parameter int DATALEN  = 8,
    parameter int NBURST   = 4,
    parameter int AXIWIDTH = 64
) (
    input  logic                                                         clk,
    input  logic                                                         we_i,
    input  logic [clog2min1(NBURST)-1:0]                                 burst_i,
    input  logic [FFTCHNL-1:0][1:0][cmplxlen(DATALEN)-1:0]               data_i,
    input  logic [clog2min1(bpt(AXIWIDTH, DATALEN, NBURST, FFTCHNL))-1:0] beat_i,
    output logic [AXIWIDTH-1:0]                                          beat_o
);
    localparam int CL   = cmplxlen(DATALEN);
    localparam int RW   = FFTCHNL * 2 * CL;
    localparam int BPTN = bpt(AXIWIDTH, DATALEN, NBURST, FFTCHNL);

    logic [0:FFTCHNL*2-1][CL-1:0]  row;
    logic [RW-1:0]                 mem_q [NBURST];
    logic [0:NBURST-1][RW-1:0]     flat;
    logic [0:BPTN-1][AXIWIDTH-1:0] beats;

    for (genvar c = 0; c < FFTCHNL; c++) begin : g_ch
        for (genvar h = 0; h < 2; h++) begin : g_half
            assign row[2*c+h] = data_i[c][h];
        end
    end

    for (genvar b = 0; b < NBURST; b++) begin : g_row
        assign flat[b] = mem_q[b];
    end

    assign beats  = flat;
    assign beat_o = beats[beat_i];

    // Store one burst row with word 0 in the most significant position; contents need no reset.
    always_ff @(posedge clk)
        if (we_i) mem_q[burst_i] <= row;

endmodule

// File: rtl/ifft_stream_writer.sv
// ifft_stream_writer: captures NBURST IFFT cycles per tile and streams masked tiles over AXI4-Stream
module ifft_stream_writer
    import ifft_stream_pkg::*;
#(
    parameter int FFTCHNL  = 8,
    parameter int DATALEN  = 8,
    parameter int PARATIL  = 9,
    parameter int NBURST   = 4,
    parameter int AXIWIDTH = 64,
    parameter int LASTMODE = 0
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic [PARATIL-1:0]                                        ifftvalid,
    input  logic [PARATIL-1:0][FFTCHNL-1:0][1:0][cmplxlen(DATALEN)-1:0] ifftdata,
    output logic                                                      axi_outvalid,
    input  logic                                                      axi_outready,
    output logic                                                      axi_outlast,
    output logic [AXIWIDTH-1:0]                                       axi_outdata,
    output logic                                                      frame_done,
    output logic                                                      overflow
);
    localparam int CL   = cmplxlen(DATALEN);
    localparam int BPTN = bpt(AXIWIDTH, DATALEN, NBURST, FFTCHNL);
    localparam int BW   = clog2min1(NBURST);
    localparam int BTW  = clog2min1(BPTN);
    localparam int TW   = clog2min1(PARATIL);
    localparam logic [BW-1:0]  BURST_LAST = BW'(NBURST - 1);
    localparam logic [BTW-1:0] BEAT_LAST  = BTW'(BPTN - 1);

    if (AXIWIDTH % CL != 0 || wpt(NBURST, FFTCHNL) % wpb(AXIWIDTH, DATALEN) != 0) begin : g_bad_geometry
        $error("ifft_stream_writer: AXIWIDTH must split each tile into a whole number of beats");
    end

    state_t             state_q;
    logic [PARATIL-1:0] mask_q, mask_d;
    logic [BW-1:0]      burst_q, widx;
    logic [BTW-1:0]     beat_q;
    logic [TW-1:0]      tile_q;
    logic               done_q, ovf_q, cap, xfer, tile_end;
    int                 first_tile, nxt_tile;
    logic [AXIWIDTH-1:0] rd [PARATIL];

    for (genvar t = 0; t < PARATIL; t++) begin : g_tile
        tile_frame_buffer #(
            .FFTCHNL(FFTCHNL), .DATALEN(DATALEN), .NBURST(NBURST), .AXIWIDTH(AXIWIDTH)
        ) u_buf (
            .clk(clk), .we_i(cap), .burst_i(widx), .data_i(ifftdata[t]), .beat_i(beat_q), .beat_o(rd[t])
        );
    end

    // Capture bookkeeping plus the first and following tiles to emit.
    always_comb begin
        cap        = |ifftvalid && state_q != STRM;
        widx       = state_q == IDLE ? '0 : burst_q;
        mask_d     = (state_q == IDLE ? '0 : mask_q) | ifftvalid;
        first_tile = next_tile(MAXTILE'(mask_d), 0, PARATIL);
        nxt_tile   = next_tile(MAXTILE'(mask_q), int'(tile_q) + 1, PARATIL);
        xfer       = axi_outvalid && axi_outready;
        tile_end   = beat_q == BEAT_LAST;
    end

    assign axi_outvalid = state_q == STRM;
    assign axi_outlast  = axi_outvalid && tile_end && (LASTMODE != 0 || nxt_tile >= PARATIL);
    assign axi_outdata  = axi_outvalid ? rd[tile_q] : '0;
    assign frame_done   = done_q;
    assign overflow     = ovf_q;

    // Frame FSM: gather bursts, then walk masked tiles beat by beat under the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            tile_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == STRM && |ifftvalid) ovf_q <= 1'b1;
            if (cap) begin
                mask_q  <= mask_d;
                burst_q <= widx == BURST_LAST ? '0 : widx + 1'b1;
                state_q <= widx == BURST_LAST ? STRM : CAPT;
                tile_q  <= TW'(first_tile);
                beat_q  <= '0;
            end
            if (xfer) begin
                beat_q <= tile_end ? '0 : beat_q + 1'b1;
                if (tile_end && nxt_tile >= PARATIL) begin
                    state_q <= IDLE;
                    mask_q  <= '0;
                    tile_q  <= '0;
                    done_q  <= 1'b1;
                end else if (tile_end) begin
                    tile_q <= TW'(nxt_tile);
                end
            end
        end
    end

endmodule

// File: tb/tb_ifft_stream_writer.sv
// tb_ifft_stream_writer: scoreboard bench over three configurations (64-bit, 32-bit, 64-bit per-tile TLAST)
module tb_ifft_stream_writer;
    localparam int P   = 9;
    localparam int F   = 8;
    localparam int NB  = 4;
    localparam int WPT = NB * F * 2;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    logic [P-1:0] ivalid = '0;
    logic [P-1:0][F-1:0][1:0][15:0] idata = '0;
    logic vld [3];
    logic lst [3];
    logic done [3];
    logic ovf [3];
    logic [63:0] dat [3];
    exp_t sbq [3][$];
    logic [15:0] mdl [P][WPT];
    logic held [3];
    logic hl [3];
    logic expd [3];
    logic [63:0] hd [3];
    int tests = 0;
    int fails = 0;
    int nb = 0;
    logic [P-1:0] mk = '0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int AW = (k == 1) ? 32 : 64;
        logic [AW-1:0] d;
        ifft_stream_writer #(
            .FFTCHNL(F), .DATALEN(8), .PARATIL(P), .NBURST(NB), .AXIWIDTH(AW), .LASTMODE((k == 2) ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst), .ifftvalid(ivalid), .ifftdata(idata),
            .axi_outvalid(vld[k]), .axi_outready(ready), .axi_outlast(lst[k]),
            .axi_outdata(d), .frame_done(done[k]), .overflow(ovf[k])
        );
        assign dat[k] = 64'(d);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [P-1:0] m);
        int lt;
        lt = 0;
        for (int t = 0; t < P; t++) if (m[t]) lt = t;
        for (int k = 0; k < 3; k++) begin
            int w;
            int nbeat;
            w = (k == 1) ? 2 : 4;
            nbeat = WPT / w;
            for (int t = 0; t < P; t++) begin
                if (m[t]) begin
                    for (int b = 0; b < nbeat; b++) begin
                        exp_t x;
                        x.d = '0;
                        for (int j = 0; j < w; j++) x.d = (x.d << 16) | 64'(mdl[t][b*w+j]);
                        x.e = (t == lt) && (b == nbeat - 1);
                        x.l = (k == 2) ? (b == nbeat - 1) : x.e;
                        sbq[k].push_back(x);
                    end
                end
            end
        end
    endtask

    task automatic randomize_data(input bit record);
        for (int t = 0; t < P; t++)
            for (int c = 0; c < F; c++)
                for (int h = 0; h < 2; h++) begin
                    idata[t][c][h] = 16'($urandom);
                    if (record) mdl[t][nb*F*2+c*2+h] = idata[t][c][h];
                end
    endtask

    task automatic capture(input logic [P-1:0] m);
        randomize_data(1'b1);
        ivalid = m;
        mk = mk | m;
        tick;
        ivalid = '0;
        nb++;
        if (nb == NB) begin
            push_frame(mk);
            nb = 0;
            mk = '0;
        end
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (n < 2000 && (sbq[0].size() + sbq[1].size() + sbq[2].size() != 0 || expd[0] || expd[1] || expd[2])) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick;
            n++;
        end
        ready = 1'b1;
        chk("drain_in_time", 64'(n < 2000), 64'd1);
        tick;
        tick;
        for (int k = 0; k < 3; k++) chk($sformatf("idle_valid%0d", k), 64'(vld[k]), 64'd0);
    endtask

    // Scoreboard monitor: pops on each transfer, checks stability under stall and the done pulse.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                held[k] = 1'b0;
                expd[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("frame_done%0d", k), 64'(done[k]), 64'(expd[k]));
                expd[k] = 1'b0;
                if (vld[k]) begin
                    if (held[k]) begin
                        chk($sformatf("stall_data%0d", k), dat[k], hd[k]);
                        chk($sformatf("stall_last%0d", k), 64'(lst[k]), 64'(hl[k]));
                    end
                    if (ready) begin
                        chk($sformatf("beat_expected%0d", k), 64'(sbq[k].size() != 0), 64'd1);
                        if (sbq[k].size() != 0) begin
                            exp_t x;
                            x = sbq[k].pop_front();
                            chk($sformatf("tdata%0d", k), dat[k], x.d);
                            chk($sformatf("tlast%0d", k), 64'(lst[k]), 64'(x.l));
                            expd[k] = x.e;
                        end
                    end
                    held[k] = !ready;
                    hd[k] = dat[k];
                    hl[k] = lst[k];
                end else begin
                    held[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), 64'(vld[k]), 64'd0);
            chk($sformatf("rst_last%0d", k), 64'(lst[k]), 64'd0);
            chk($sformatf("rst_data%0d", k), dat[k], 64'd0);
            chk($sformatf("rst_done%0d", k), 64'(done[k]), 64'd0);
            chk($sformatf("rst_ovf%0d", k), 64'(ovf[k]), 64'd0);
        end
        rst = 1'b0;
        ready = 1'b1;
        tick;

        repeat (NB) capture('1);
        for (int k = 0; k < 3; k++) chk($sformatf("latency_valid%0d", k), 64'(vld[k]), 64'd1);
        drain(1'b0);

        repeat (NB) capture(9'b000100101);
        drain(1'b0);

        repeat (NB) capture('1);
        drain(1'b1);

        capture(9'h0F0);
        tick;
        tick;
        capture(9'h0F0);
        capture(9'h0F0);
        repeat (4) tick;
        chk("gap_no_early_valid", 64'(vld[0]), 64'd0);
        capture(9'h0F0);
        for (int k = 0; k < 3; k++) chk($sformatf("gap_latency_valid%0d", k), 64'(vld[k]), 64'd1);
        drain(1'b0);

        repeat (NB) capture('1);
        repeat (10) tick;
        randomize_data(1'b0);
        ivalid = 9'h003;
        tick;
        ivalid = '0;
        for (int k = 0; k < 3; k++) chk($sformatf("ovf_set%0d", k), 64'(ovf[k]), 64'd1);
        repeat (5) tick;
        chk("ovf_sticky", 64'(ovf[0]), 64'd1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst_valid%0d", k), 64'(vld[k]), 64'd0);
            chk($sformatf("midrst_ovf%0d", k), 64'(ovf[k]), 64'd0);
            sbq[k].delete();
        end
        nb = 0;
        mk = '0;
        tick;
        rst = 1'b0;
        tick;

        repeat (NB) capture(9'h100);
        drain(1'b0);
        for (int k = 0; k < 3; k++) chk($sformatf("post_ovf%0d", k), 64'(ovf[k]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
